// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the ALU/LSU requesters, the arbiter and the register file.
// A requester's transfer happens on a rising clk edge where its *_valid_i and *_ready_o are both high.
// ready is combinational from valid, so a requester must not wait for ready before raising valid.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              alu_valid_i;
  logic [REG_AW-1:0] alu_dest_pi;
  logic [DATA_W-1:0] alu_data_pi;
  logic              alu_ready_o;
  logic              lsu_valid_i;
  logic [REG_AW-1:0] lsu_dest_pi;
  logic [DATA_W-1:0] lsu_data_pi;
  logic              lsu_ready_o;
  logic              hold_i;
  logic              we_o;
  logic [REG_AW-1:0] destReg_po;
  logic [DATA_W-1:0] writeData_po;
  logic [15:0]       conflict_cnt_po;

  modport master (
    output alu_valid_i, alu_dest_pi, alu_data_pi,
    output lsu_valid_i, lsu_dest_pi, lsu_data_pi,
    output hold_i,
    input  alu_ready_o, lsu_ready_o,
    input  we_o, destReg_po, writeData_po, conflict_cnt_po
  );

  modport slave (
    input  alu_valid_i, alu_dest_pi, alu_data_pi,
    input  lsu_valid_i, lsu_dest_pi, lsu_data_pi,
    input  hold_i,
    output alu_ready_o, lsu_ready_o,
    output we_o, destReg_po, writeData_po, conflict_cnt_po
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter merging ALU and load-unit writebacks onto a single register-file write port.
// o_last_grant exposes the round-robin state: 0 = ALU took the last transfer, 1 = LSU did.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_wb_arbiter_if.slave  bus,
  output logic                 o_last_grant
);

  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_LSU = 1'b1
  } last_e;

  last_e             r_last;
  last_e             w_last_nxt;
  logic              w_alu_gnt;
  logic              w_lsu_gnt;
  logic              w_conflict;
  logic              r_we;
  logic [REG_AW-1:0] r_dest;
  logic [DATA_W-1:0] r_data;
  logic [15:0]       r_cnt;

  assign w_conflict = bus.alu_valid_i && bus.lsu_valid_i && !bus.hold_i;

  // Grant logic is gated by reset so no transfer can start while the block is held in reset.
  always_comb begin
    w_alu_gnt  = 1'b0;
    w_lsu_gnt  = 1'b0;
    w_last_nxt = r_last;
    if (!reset && !bus.hold_i) begin
      if (bus.alu_valid_i && (!bus.lsu_valid_i || r_last == LAST_LSU)) begin
        w_alu_gnt = 1'b1;
      end else if (bus.lsu_valid_i) begin
        w_lsu_gnt = 1'b1;
      end
    end
    if (w_alu_gnt) begin
      w_last_nxt = LAST_ALU;
    end else if (w_lsu_gnt) begin
      w_last_nxt = LAST_LSU;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= LAST_LSU;
    end else begin
      r_last <= w_last_nxt;
    end
  end

  // x0 writes still complete the handshake but never raise the write enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_dest <= '0;
      r_data <= '0;
    end else begin
      r_we <= (w_alu_gnt && bus.alu_dest_pi != '0) ||
              (w_lsu_gnt && bus.lsu_dest_pi != '0);
      if (w_alu_gnt) begin
        r_dest <= bus.alu_dest_pi;
        r_data <= bus.alu_data_pi;
      end else if (w_lsu_gnt) begin
        r_dest <= bus.lsu_dest_pi;
        r_data <= bus.lsu_data_pi;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_conflict && r_cnt != 16'hFFFF) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign bus.alu_ready_o     = w_alu_gnt;
  assign bus.lsu_ready_o     = w_lsu_gnt;
  assign bus.we_o            = r_we;
  assign bus.destReg_po      = r_dest;
  assign bus.writeData_po    = r_data;
  assign bus.conflict_cnt_po = r_cnt;
  assign o_last_grant        = (r_last == LAST_LSU);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic, scoreboarded against a
// reference model that tracks only "who wrote last" and a saturating conflict count.
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int W      = 2 + REG_AW + DATA_W + 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic o_last_grant;
  int   total = 0;
  int   bad   = 0;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  regfile_wb_arbiter #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .o_last_grant (o_last_grant)
  );

  always #5 clk = ~clk;

  // Expected item: {last_is_lsu, we, dest, data, conflict_cnt} after the next rising edge.
  logic [W-1:0] exp_q[$];
  bit           m_last_alu;
  int           m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_last_alu = 1'b0;
    m_cnt      = 0;
  endtask

  // One bus cycle: drive at negedge, check ready, predict the registered outputs.
  task automatic cycle(input bit av, input logic [REG_AW-1:0] ad, input logic [DATA_W-1:0] adat,
                       input bit lv, input logic [REG_AW-1:0] ld, input logic [DATA_W-1:0] ldat,
                       input bit h);
    bit                ea;
    bit                el;
    bit                e_we;
    logic [REG_AW-1:0] e_dest;
    logic [DATA_W-1:0] e_data;
    @(negedge clk);
    bus.alu_valid_i = av;
    bus.alu_dest_pi = ad;
    bus.alu_data_pi = adat;
    bus.lsu_valid_i = lv;
    bus.lsu_dest_pi = ld;
    bus.lsu_data_pi = ldat;
    bus.hold_i      = h;
    #1;
    ea = 1'b0;
    el = 1'b0;
    if (!h) begin
      if (av && lv) begin
        ea = !m_last_alu;
        el = m_last_alu;
      end else begin
        ea = av;
        el = lv;
      end
    end
    check("alu_ready", bus.alu_ready_o, ea);
    check("lsu_ready", bus.lsu_ready_o, el);
    if (av && lv && !h && m_cnt < 65535) m_cnt++;
    e_we   = 1'b0;
    e_dest = '0;
    e_data = '0;
    if (ea) begin
      m_last_alu = 1'b1;
      e_we = (ad != 0); e_dest = ad; e_data = adat;
    end else if (el) begin
      m_last_alu = 1'b0;
      e_we = (ld != 0); e_dest = ld; e_data = ldat;
    end
    exp_q.push_back({!m_last_alu, e_we, e_dest, e_data, m_cnt[15:0]});
  endtask

  task automatic idle_inputs();
    bus.alu_valid_i = 1'b0;
    bus.lsu_valid_i = 1'b0;
    bus.hold_i      = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_we", bus.we_o, 1'b0);
    check("rst_dest", bus.destReg_po, '0);
    check("rst_data", bus.writeData_po, '0);
    check("rst_cnt", bus.conflict_cnt_po, 16'd0);
    check("rst_last", o_last_grant, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every negedge the outputs registered at the previous rising edge are compared.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      check("last_grant", o_last_grant, e[W-1]);
      check("we", bus.we_o, e[W-2]);
      check("cnt", bus.conflict_cnt_po, e[15:0]);
      if (e[W-2]) begin
        check("dest", bus.destReg_po, e[16+DATA_W +: REG_AW]);
        check("data", bus.writeData_po, e[16 +: DATA_W]);
      end
    end
  end

  initial begin
    bus.alu_dest_pi = '0;
    bus.alu_data_pi = '0;
    bus.lsu_dest_pi = '0;
    bus.lsu_data_pi = '0;
    idle_inputs();
    model_reset();
    #2;
    reset = 1'b1;
    bus.alu_valid_i = 1'b1;
    bus.lsu_valid_i = 1'b1;
    #1;
    check("rst_ready_alu", bus.alu_ready_o, 1'b0);
    check("rst_ready_lsu", bus.lsu_ready_o, 1'b0);
    do_reset();

    // Single ALU write to x3.
    cycle(1, 5'd3, 32'h0000_00AA, 0, '0, '0, 0);
    do_reset();

    // Four contended cycles alternate ALU, LSU, ALU, LSU.
    repeat (4) cycle(1, 5'd1, $urandom, 1, 5'd2, $urandom, 0);

    // LSU write to x0 is accepted but suppressed; the next conflict goes to ALU.
    cycle(0, '0, '0, 1, 5'd0, 32'hDEAD_BEEF, 0);
    cycle(1, 5'd7, 32'h1111_2222, 1, 5'd8, 32'h3333_4444, 0);

    // Hold freezes both requesters and the counter; release grants ALU after an LSU transfer.
    cycle(0, '0, '0, 1, 5'd9, 32'h5555_6666, 0);
    repeat (3) cycle(1, 5'd10, $urandom, 1, 5'd11, $urandom, 1);
    cycle(1, 5'd12, 32'h7777_8888, 1, 5'd13, 32'h9999_AAAA, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 99) < 60, REG_AW'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 99) < 60, REG_AW'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 99) < 15);
    end

    // Reset right after an ALU acceptance: the write never appears.
    cycle(1, 5'd4, 32'hCAFE_F00D, 1, 5'd6, 32'h0BAD_0BAD, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    check("mid_rst_we", bus.we_o, 1'b0);
    check("mid_rst_cnt", bus.conflict_cnt_po, 16'd0);
    check("mid_rst_ready_alu", bus.alu_ready_o, 1'b0);
    check("mid_rst_ready_lsu", bus.lsu_ready_o, 1'b0);
    repeat (2) begin
      @(negedge clk);
      #1;
      check("mid_rst_hold_we", bus.we_o, 1'b0);
    end
    idle_inputs();
    reset = 1'b0;
    cycle(0, '0, '0, 0, '0, '0, 0);

    // Counter saturation.
    for (int i = 0; i < 32'h10005; i++) begin
      cycle(1, REG_AW'($urandom_range(0, 31)), $urandom, 1, REG_AW'($urandom_range(0, 31)), $urandom, 0);
    end
    cycle(1, 5'd5, $urandom, 1, 5'd6, $urandom, 0);

    @(negedge clk);
    idle_inputs();
    #2;
    check("sat_cnt", bus.conflict_cnt_po, 16'hFFFF);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of writeback data.
REQ-002 SHALL have parameter REG_AW, default 5, meaning width of register index.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port alu_valid_i  input  1  ALU writeback request.
REQ-006 SHALL have port alu_dest_pi  input  REG_AW  ALU destination register.
REQ-007 SHALL have port alu_data_pi  input  DATA_W  ALU writeback data.
REQ-008 SHALL have port alu_ready_o  output  1  ALU request accepted this cycle.
REQ-009 SHALL have port lsu_valid_i  input  1  load-unit writeback request.
REQ-010 SHALL have port lsu_dest_pi  input  REG_AW  load-unit destination register.
REQ-011 SHALL have port lsu_data_pi  input  DATA_W  load-unit writeback data.
REQ-012 SHALL have port lsu_ready_o  output  1  load-unit request accepted this cycle.
REQ-013 SHALL have port hold_i  input  1  freeze arbitration (debug/stall), no grants while high.
REQ-014 SHALL have port we_o  output  1  register-file write enable (drives regfile we_i).
REQ-015 SHALL have port destReg_po  output  REG_AW  register-file write index (drives destReg_pi).
REQ-016 SHALL have port writeData_po  output  DATA_W  register-file write data (drives writeData_pi).
REQ-017 SHALL have port conflict_cnt_po  output  16  count of cycles with both requesters contending.

Function
REQ-018 SHALL accept a request (transfer) in a cycle where its valid and its ready are both high at the clk edge.
REQ-019 SHALL drive ready outputs combinationally from valid inputs, hold_i and round-robin state; at most one ready high per cycle.
REQ-020 SHALL grant no requester while hold_i=1 (both ready low), regardless of valids.
REQ-021 SHALL grant the sole valid requester when exactly one valid is high and hold_i=0.
REQ-022 SHALL, when both valid and hold_i=0, grant the requester not recorded in last-grant state (round-robin).
REQ-023 SHALL update last-grant state to the granted requester on every transfer; unchanged otherwise.
REQ-024 SHALL register the accepted payload: we_o, destReg_po, writeData_po reflect the transfer exactly one cycle after acceptance.
REQ-025 SHALL drive we_o=0 in the cycle after a transfer whose dest is 0 (x0 write suppressed); the transfer still completes and updates last-grant.
REQ-026 SHALL drive we_o=0 in any cycle not preceded by a transfer; destReg_po and writeData_po hold last values.
REQ-027 SHALL sustain one transfer per cycle (no bubble) under back-to-back requests.
REQ-028 SHALL increment conflict_cnt_po in each cycle with alu_valid_i=1, lsu_valid_i=1, hold_i=0, saturating at 0xFFFF.
REQ-029 SHALL not require requester payload to be stable except in the accepting cycle; a valid dropped before grant is discarded without side effect.

Reset
REQ-030 SHALL, on reset assertion, immediately force we_o=0, destReg_po=0, writeData_po=0, conflict_cnt_po=0, last-grant=LSU (so ALU wins first conflict).
REQ-031 SHALL drive both ready outputs low while reset is high; a transfer in flight at reset assertion is lost and never written.
REQ-032 SHALL resume normal arbitration on the first clk edge after reset deassertion.

Verification
REQ-033 SHALL pass: ALU only, dest=3, data=0x0000_00AA -> alu_ready_o=1 same cycle; next cycle we_o=1, destReg_po=3, writeData_po=0xAA.
REQ-034 SHALL pass: both valid 4 consecutive cycles after reset (ALU dest=1, LSU dest=2) -> grants ALU, LSU, ALU, LSU; we_o=1 each following cycle; conflict_cnt_po=4.
REQ-035 SHALL pass: LSU dest=0, data=0xDEAD_BEEF -> lsu_ready_o=1; next cycle we_o=0; following conflict grants ALU.
REQ-036 SHALL pass: both valid with hold_i=1 for 3 cycles -> no ready, we_o=0, conflict_cnt_po unchanged; hold_i=0 -> ALU granted.
REQ-037 SHALL pass: reset asserted mid-cycle after ALU acceptance -> we_o=0 asynchronously, no write issued, conflict_cnt_po=0.
REQ-038 SHALL pass: force 0x10005 contending cycles -> conflict_cnt_po stays 0xFFFF.
